// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   Memory-mapped UART transmitter on the core's data-memory port. Stores to
//   TXDATA queue bytes in a TX FIFO. A bit-serial FSM shifts each byte out on
//   Tx as a start bit, 8 data bits (LSB first) and a stop bit. Loads return
//   status and configuration.
//
//   Register window (16 bytes at BASE_ADDR, word aligned accesses only):
//     0x0 TXDATA  W: push DataWr[7:0]            R: 0
//     0x4 STATUS  R: {count[11:8], ovf[3], busy[2], empty[1], full[0]}
//                 W: 1 to bit3 clears the sticky overflow
//     0x8 BAUDDIV R/W [15:0] clock cycles per bit (0 behaves as 1)
//     0xC CTRL    R/W bit0 enable (reset 1), bit1 parity enable
//
// Ports:
//   Clk      in   system clock, rising edge
//   Rst      in   synchronous active-high reset
//   Address  in   [31:0] byte address from the core
//   DataWr   in   [31:0] store data
//   DMWr     in   store strobe
//   DMCtrl   in   [2:0] funct3 access size (B/H/W/BU/HU)
//   DataRd   out  [31:0] load data, combinational
//   Tx       out  serial line, idle high
//
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit, enabled by CTRL bit1. Without the
// macro the frame is fixed 8N1 and CTRL bit1 reads 0.

module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Address,
  input  logic [31:0] DataWr,
  input  logic        DMWr,
  input  logic [2:0]  DMCtrl,
  output logic [31:0] DataRd,
  output logic        Tx
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_BAUD   = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // Load sizing: sign- or zero-extend the low byte/halfword of a register.
  function automatic logic [31:0] sizeLoad(input logic [31:0] w, input logic [2:0] ctrl);
    case (ctrl)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b010:  return w;
      3'b100:  return {24'b0, w[7:0]};
      3'b101:  return {16'b0, w[15:0]};
      default: return 32'b0;
    endcase
  endfunction

  state_t           state;
  logic [7:0]       fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic [15:0]      baudDiv;
  logic             enable;
  logic [7:0]       shiftReg;
  logic [15:0]      bitTimer;
  logic [2:0]       bitIdx;
`ifdef UART_TX_PARITY_EN
  logic             parityEn;
  logic             parityBit;
`endif

  logic        sel, wr, pushReq, pushOk, pop, full, empty, busy, bitEnd;
  logic [1:0]  offset;
  logic [15:0] effDiv, bitLoad;
  logic [3:0]  cnt4;
  logic [31:0] statusWord, ctrlWord, regWord;
  logic        unusedDataHi;

  assign sel     = (Address[31:4] == BASE_ADDR[31:4]) && (Address[1:0] == 2'b00);
  assign offset  = Address[3:2];
  assign wr      = sel && DMWr;
  assign pushReq = wr && (offset == OFF_TXDATA);
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign busy    = (state != S_IDLE);
  assign pop     = (state == S_IDLE) && enable && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign pushOk  = pushReq && (!full || pop);
  assign effDiv  = (baudDiv == 16'd0) ? 16'd1 : baudDiv;
  assign bitLoad = effDiv - 16'd1;
  assign bitEnd  = (bitTimer == 16'd0);
  assign cnt4    = 4'(count);
  assign unusedDataHi = ^DataWr[31:16];

  // ---- FIFO control
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (pop)    rdPtr <= rdPtr + 1'b1;
      case ({pushOk, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pushReq && !pushOk)
        overflow <= 1'b1;
      else if (wr && (offset == OFF_STATUS) && DataWr[3])
        overflow <= 1'b0;
    end
  end

  // ---- FIFO storage
  always_ff @(posedge Clk) begin
    if (pushOk) fifoMem[wrPtr] <= DataWr[7:0];
  end

  // ---- Configuration registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      baudDiv  <= DEFAULT_DIV;
      enable   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parityEn <= 1'b0;
`endif
    end else if (wr) begin
      case (offset)
        OFF_BAUD: begin
          if (DMCtrl == 3'b000) baudDiv[7:0] <= DataWr[7:0];
          else                  baudDiv      <= DataWr[15:0];
        end
        OFF_CTRL: begin
          enable   <= DataWr[0];
`ifdef UART_TX_PARITY_EN
          parityEn <= DataWr[1];
`endif
        end
        default: ;
      endcase
    end
  end

  // ---- Shift datapath: load on pop, shift after each start/data bit
  always_ff @(posedge Clk) begin
    if (pop) begin
      shiftReg  <= fifoMem[rdPtr];
`ifdef UART_TX_PARITY_EN
      parityBit <= ^fifoMem[rdPtr];
`endif
    end else if (bitEnd && ((state == S_START) || (state == S_DATA))) begin
      shiftReg <= shiftReg >> 1;
    end
  end

  // ---- Transmit FSM; Tx is registered and changes together with state.
  // The bit timer reloads from the divider at each bit start, so divider
  // writes land on the following bit.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= S_IDLE;
      Tx       <= 1'b1;
      bitTimer <= '0;
      bitIdx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          Tx <= 1'b1;
          if (pop) begin
            state    <= S_START;
            Tx       <= 1'b0;
            bitTimer <= bitLoad;
          end
        end
        S_START: begin
          if (bitEnd) begin
            state    <= S_DATA;
            Tx       <= shiftReg[0];
            bitIdx   <= 3'd0;
            bitTimer <= bitLoad;
          end else begin
            bitTimer <= bitTimer - 16'd1;
          end
        end
        S_DATA: begin
          if (bitEnd) begin
            bitTimer <= bitLoad;
            if (bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              if (parityEn) begin
                state <= S_PARITY;
                Tx    <= parityBit;
              end else begin
                state <= S_STOP;
                Tx    <= 1'b1;
              end
`else
              state <= S_STOP;
              Tx    <= 1'b1;
`endif
            end else begin
              Tx     <= shiftReg[0];
              bitIdx <= bitIdx + 3'd1;
            end
          end else begin
            bitTimer <= bitTimer - 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bitEnd) begin
            state    <= S_STOP;
            Tx       <= 1'b1;
            bitTimer <= bitLoad;
          end else begin
            bitTimer <= bitTimer - 16'd1;
          end
        end
`endif
        S_STOP: begin
          Tx <= 1'b1;
          if (bitEnd) state <= S_IDLE;
          else        bitTimer <= bitTimer - 16'd1;
        end
        default: begin
          state <= S_IDLE;
          Tx    <= 1'b1;
        end
      endcase
    end
  end

  // ---- Load path
  assign statusWord = {20'b0, cnt4, 4'b0, overflow, busy, empty, full};
`ifdef UART_TX_PARITY_EN
  assign ctrlWord = {30'b0, parityEn, enable};
`else
  assign ctrlWord = {31'b0, enable};
`endif

  always_comb begin
    regWord = 32'b0;
    if (sel) begin
      case (offset)
        OFF_STATUS: regWord = statusWord;
        OFF_BAUD:   regWord = {16'b0, baudDiv};
        OFF_CTRL:   regWord = ctrlWord;
        default:    regWord = 32'b0;
      endcase
    end
    DataRd = sizeLoad(regWord, DMCtrl);
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx
//   Randomized self-checking bench for mmio_uart_tx. A behavioural model keeps
//   the queued bytes in a queue and derives the expected serial waveform from
//   the frame format (start, LSB-first data, optional parity, stop) and the
//   effective divider, cycle by cycle.

module tb_mmio_uart_tx;

  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam logic [31:0] A_TXD  = BASE + 32'h0;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_BAUD = BASE + 32'h8;
  localparam logic [31:0] A_CTRL = BASE + 32'hC;
  localparam int DEPTH = 8;
  localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010,
                         SZ_BU = 3'b100, SZ_HU = 3'b101;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] Address, DataWr, DataRd;
  logic        DMWr;
  logic [2:0]  DMCtrl;
  logic        Tx;

  mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd868)) dut (
    .Clk(Clk), .Rst(Rst), .Address(Address), .DataWr(DataWr), .DMWr(DMWr),
    .DMCtrl(DMCtrl), .DataRd(DataRd), .Tx(Tx)
  );

  always #5 Clk = ~Clk;

  int nChecks = 0;
  int nFails  = 0;
  logic [7:0] mQ[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
    Address = a; DataWr = d; DMCtrl = c; DMWr = 1'b1;
    @(posedge Clk); #1;
    DMWr = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] c, output logic [31:0] d);
    Address = a; DMCtrl = c; DMWr = 1'b0;
    #1;
    d = DataRd;
  endtask

  function automatic logic [31:0] expStatus(input int cnt, input bit ovf, input bit bsy);
    return 32'((cnt << 8) + (ovf ? 8 : 0) + (bsy ? 4 : 0) + ((cnt == 0) ? 2 : 0) + ((cnt == DEPTH) ? 1 : 0));
  endfunction

  function automatic logic [31:0] expSized(input logic [31:0] w, input logic [2:0] c);
    logic [7:0]  lo8  = w[7:0];
    logic [15:0] lo16 = w[15:0];
    case (c)
      SZ_B:    return 32'($signed(lo8));
      SZ_H:    return 32'($signed(lo16));
      SZ_W:    return w;
      SZ_BU:   return {24'b0, lo8};
      SZ_HU:   return {16'b0, lo16};
      default: return 32'b0;
    endcase
  endfunction

  // Line level of bit i of a frame carrying byte b.
  function automatic logic frameBit(input logic [7:0] b, input int i, input bit par);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (par && i == 9) return ^b;
    return 1'b1;
  endfunction

  // Entered 1ns after the edge on which the first start bit appears.
  task automatic checkStream(input int n, input int div, input bit par);
    int eff = (div == 0) ? 1 : div;
    int nBits = par ? 11 : 10;
    logic [31:0] st;
    for (int j = 0; j < n; j++) begin
      logic [7:0] b = mQ.pop_front();
      for (int c = 0; c < nBits * eff; c++) begin
        check("tx_bit", 32'(Tx), 32'(frameBit(b, c / eff, par)));
        load(A_STAT, SZ_W, st);
        check("busy_in_frame", 32'(st[2]), 32'd1);
        check("count_in_frame", 32'(st[11:8]), 32'(mQ.size()));
        @(posedge Clk); #1;
      end
      check("tx_idle_gap", 32'(Tx), 32'd1);
      load(A_STAT, SZ_W, st);
      check("busy_idle_gap", 32'(st[2]), 32'd0);
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  b;
    int div, n, waitCnt;

    Rst = 1'b1; Address = 32'b0; DataWr = 32'b0; DMWr = 1'b0; DMCtrl = SZ_W;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;

    // Reset state
    load(A_STAT, SZ_W, rd); check("rst_status", rd, 32'h2);
    load(A_BAUD, SZ_W, rd); check("rst_baud", rd, 32'd868);
    load(A_CTRL, SZ_W, rd); check("rst_ctrl", rd, 32'h1);
    load(A_TXD, SZ_W, rd);  check("txdata_read", rd, 32'h0);
    check("rst_tx", 32'(Tx), 32'd1);

    // Single 0xA5 frame at 4 cycles per bit
    store(A_BAUD, 32'h4, SZ_W);
    store(A_TXD, 32'hA5, SZ_B);
    mQ.push_back(8'hA5);
    @(posedge Clk); #1;
    checkStream(1, 4, 0);
    load(A_STAT, SZ_W, rd); check("after_a5_status", rd, 32'h2);

    // Disabled: fill past capacity
    store(A_CTRL, 32'h0, SZ_W);
    store(A_BAUD, 32'h2, SZ_W);
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      store(A_TXD, {24'b0, b}, SZ_B);
      if (mQ.size() < DEPTH) mQ.push_back(b);
    end
    load(A_STAT, SZ_W, rd); check("ovf_status", rd, expStatus(8, 1, 0));
    check("ovf_tx_idle", 32'(Tx), 32'd1);
    store(A_STAT, 32'h8, SZ_W);
    load(A_STAT, SZ_W, rd); check("ovf_clear", rd, expStatus(8, 0, 0));

    // Enable, then push while full on the same edge as the first pop
    store(A_CTRL, 32'h1, SZ_W);
    b = 8'($urandom);
    store(A_TXD, {24'b0, b}, SZ_B);
    mQ.push_back(b);
    checkStream(9, 2, 0);
    load(A_STAT, SZ_W, rd); check("full_pushpop_status", rd, 32'h2);

    // Misaligned and unselected accesses
    store(32'h0000_1002, 32'h55, SZ_W);
    store(32'h0000_100A, 32'hFFFF, SZ_W);
    store(32'h0000_2008, 32'h1234, SZ_W);
    load(A_STAT, SZ_W, rd); check("misalign_no_push", rd, 32'h2);
    load(A_BAUD, SZ_W, rd); check("misalign_baud", rd, 32'h2);
    load(32'h0000_1006, SZ_W, rd); check("misalign_read", rd, 32'h0);
    load(32'h0000_2008, SZ_W, rd); check("unsel_read", rd, 32'h0);

    // Load sizing and byte stores
    store(A_STAT, 32'h80, SZ_B);
    load(A_STAT, SZ_W, rd); check("status_sb", rd, 32'h2);
    store(A_BAUD, 32'h80, SZ_W);
    load(A_BAUD, SZ_B, rd);  check("lb", rd, 32'hFFFF_FF80);
    load(A_BAUD, SZ_BU, rd); check("lbu", rd, 32'h0000_0080);
    load(A_BAUD, SZ_H, rd);  check("lh", rd, 32'h0000_0080);
    load(A_BAUD, SZ_HU, rd); check("lhu", rd, 32'h0000_0080);
    load(A_BAUD, 3'b011, rd); check("bad_size", rd, 32'h0);
    store(A_BAUD, 32'hDEAD_8080, SZ_H);
    load(A_BAUD, SZ_H, rd);  check("lh_neg", rd, 32'hFFFF_8080);
    store(A_BAUD, 32'hFFFF_FF12, SZ_B);
    load(A_BAUD, SZ_W, rd);  check("sb_baud", rd, 32'h0000_8012);
    store(A_CTRL, 32'hFFFF_FFFE, SZ_W);
    load(A_CTRL, SZ_W, rd);  check("ctrl_dis", rd, 32'h0);
    store(A_CTRL, 32'hFFFF_FFFF, SZ_W);
    load(A_CTRL, SZ_W, rd);
`ifdef UART_TX_PARITY_EN
    check("ctrl_all", rd, 32'h3);
`else
    check("ctrl_all", rd, 32'h1);
`endif
    store(A_CTRL, 32'h1, SZ_W);

    // Randomized bursts
    for (int it = 0; it < 6; it++) begin
      logic [2:0] sz;
      div = $urandom_range(0, 4);
      n = $urandom_range(1, 4);
      store(A_CTRL, 32'h0, SZ_W);
      store(A_BAUD, {16'($urandom), 16'(div)}, SZ_W);
      sz = 3'($urandom_range(0, 7));
      load(A_BAUD, sz, rd); check("rand_baud_read", rd, expSized(32'(div), sz));
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        store(A_TXD, {24'($urandom), b}, SZ_W);
        mQ.push_back(b);
      end
      load(A_STAT, SZ_W, rd); check("rand_status", rd, expStatus(n, 0, 0));
      store(A_CTRL, 32'h1, SZ_W);
      @(posedge Clk); #1;
      checkStream(n, div, 0);
    end

    // Clearing enable mid-frame finishes the frame and retains the FIFO
    store(A_BAUD, 32'h3, SZ_W);
    b = 8'($urandom);
    store(A_TXD, {24'b0, b}, SZ_B);
    mQ.push_back(b);
    b = 8'($urandom);
    store(A_TXD, {24'b0, b}, SZ_B);
    mQ.push_back(b);
    store(A_CTRL, 32'h0, SZ_W);
    waitCnt = 0;
    load(A_STAT, SZ_W, rd);
    while (rd[2] && waitCnt < 200) begin
      @(posedge Clk); #1;
      load(A_STAT, SZ_W, rd);
      waitCnt++;
    end
    check("en_clear_timeout", 32'(waitCnt < 200), 32'd1);
    check("en_clear_status", rd, expStatus(1, 0, 0));
    repeat (20) @(posedge Clk);
    #1;
    load(A_STAT, SZ_W, rd); check("en_clear_hold", rd, expStatus(1, 0, 0));
    check("en_clear_tx", 32'(Tx), 32'd1);
    void'(mQ.pop_front());
    store(A_CTRL, 32'h1, SZ_W);
    @(posedge Clk); #1;
    checkStream(1, 3, 0);

    // Reset during data bit 3
    store(A_BAUD, 32'h4, SZ_W);
    store(A_TXD, 32'h3C, SZ_B);
    store(A_TXD, 32'h11, SZ_B);
    store(A_TXD, 32'h22, SZ_B);
    repeat (16) @(posedge Clk);
    #1;
    check("pre_rst_bit3", 32'(Tx), 32'(frameBit(8'h3C, 4, 0)));
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    check("rst_mid_tx", 32'(Tx), 32'd1);
    load(A_STAT, SZ_W, rd); check("rst_mid_status", rd, 32'h2);
    load(A_BAUD, SZ_W, rd); check("rst_mid_baud", rd, 32'd868);
    repeat (10) @(posedge Clk);
    #1;
    check("rst_mid_quiet", 32'(Tx), 32'd1);
    mQ.delete();

`ifdef UART_TX_PARITY_EN
    // Even parity frames
    store(A_BAUD, 32'h2, SZ_W);
    store(A_CTRL, 32'h3, SZ_W);
    store(A_TXD, 32'h07, SZ_B);
    mQ.push_back(8'h07);
    @(posedge Clk); #1;
    checkStream(1, 2, 1);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      store(A_TXD, {24'b0, b}, SZ_B);
      mQ.push_back(b);
      @(posedge Clk); #1;
      checkStream(1, 2, 1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
